// File: rtl/md5_pkg.sv
// Shared MD5 message-scheduler definitions: step constants, shift table,
// scheduler state encoding and widths.
package md5_pkg;

  localparam int unsigned WORD_W  = 32;
  localparam int unsigned STEP_W  = 6;
  localparam int unsigned WIDX_W  = 4;
  localparam int unsigned NWORDS  = 16;
  localparam int unsigned NSTEPS  = 64;

  typedef enum logic {
    ST_LOAD = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  // T[i] = floor(2^32 * |sin(i+1)|)
  localparam logic [WORD_W-1:0] T_TABLE [NSTEPS] = '{
    32'hd76aa478, 32'he8c7b756, 32'h242070db, 32'hc1bdceee,
    32'hf57c0faf, 32'h4787c62a, 32'ha8304613, 32'hfd469501,
    32'h698098d8, 32'h8b44f7af, 32'hffff5bb1, 32'h895cd7be,
    32'h6b901122, 32'hfd987193, 32'ha679438e, 32'h49b40821,
    32'hf61e2562, 32'hc040b340, 32'h265e5a51, 32'he9b6c7aa,
    32'hd62f105d, 32'h02441453, 32'hd8a1e681, 32'he7d3fbc8,
    32'h21e1cde6, 32'hc33707d6, 32'hf4d50d87, 32'h455a14ed,
    32'ha9e3e905, 32'hfcefa3f8, 32'h676f02d9, 32'h8d2a4c8a,
    32'hfffa3942, 32'h8771f681, 32'h6d9d6122, 32'hfde5380c,
    32'ha4beea44, 32'h4bdecfa9, 32'hf6bb4b60, 32'hbebfbc70,
    32'h289b7ec6, 32'heaa127fa, 32'hd4ef3085, 32'h04881d05,
    32'hd9d4d039, 32'he6db99e5, 32'h1fa27cf8, 32'hc4ac5665,
    32'hf4292244, 32'h432aff97, 32'hab9423a7, 32'hfc93a039,
    32'h655b59c3, 32'h8f0ccc92, 32'hffeff47d, 32'h85845dd1,
    32'h6fa87e4f, 32'hfe2ce6e0, 32'ha3014314, 32'h4e0811a1,
    32'hf7537e82, 32'hbd3af235, 32'h2ad7d2bb, 32'heb86d391
  };

  // Indexed by {round, step[1:0]}
  localparam logic [4:0] SHIFT_TABLE [NWORDS] = '{
    5'd7, 5'd12, 5'd17, 5'd22,
    5'd5, 5'd9,  5'd14, 5'd20,
    5'd4, 5'd11, 5'd16, 5'd23,
    5'd6, 5'd10, 5'd15, 5'd21
  };

endpackage

// File: rtl/md5_k_index.sv
// Maps an MD5 step index to the message word index k used by that step.
module md5_k_index
  import md5_pkg::*;
(
  input  logic [5:0] step,
  output logic [3:0] k
);

  logic [3:0] i4;

  always_comb begin
    i4 = step[3:0];
    k  = i4;
    unique case (step[5:4])
      2'd0: k = i4;
      2'd1: k = (i4 * 4'd5) + 4'd1;
      2'd2: k = (i4 * 4'd3) + 4'd5;
      2'd3: k = i4 * 4'd7;
      default: k = i4;
    endcase
  end

endmodule

// File: rtl/md5_msg_sched.sv
// MD5 message scheduler: collects a 16-word block, then streams the 64
// per-step (X[k], T[i], s) tuples to the round datapath with valid/ready.
module md5_msg_sched
  import md5_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flush,
  input  logic        in_valid,
  input  logic [31:0] in_word,
  output logic        in_ready,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] msg,
  output logic [31:0] t,
  output logic [4:0]  shift,
  output logic [5:0]  step,
  output logic [1:0]  rnd,
  output logic        last,
  output logic        done
);

  state_t      state, state_nxt;
  logic [3:0]  wcnt;
  logic [5:0]  step_q;
  logic        done_q;
  logic [31:0] x [NWORDS];
  logic [3:0]  k;
  logic        accept;
  logic        fire;

  md5_k_index u_k_index (
    .step (step_q),
    .k    (k)
  );

  always_comb begin
    in_ready  = (state == ST_LOAD);
    out_valid = (state == ST_RUN);
    accept    = in_valid && in_ready;
    fire      = out_valid && out_ready;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_LOAD: if (accept && (wcnt == 4'd15)) state_nxt = ST_RUN;
      ST_RUN:  if (fire && (step_q == 6'd63)) state_nxt = ST_LOAD;
      default: state_nxt = ST_LOAD;
    endcase
    if (flush) state_nxt = ST_LOAD;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_LOAD;
    else        state <= state_nxt;
  end

  // step wraps 63 -> 0 on its own, so block end needs no explicit clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wcnt   <= '0;
      step_q <= '0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (flush) begin
        wcnt   <= '0;
        step_q <= '0;
      end else begin
        if (accept) wcnt <= wcnt + 4'd1;
        if (fire) begin
          step_q <= step_q + 6'd1;
          done_q <= (step_q == 6'd63);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned j = 0; j < NWORDS; j++) x[j] <= '0;
    end else if (accept && !flush) begin
      x[wcnt] <= in_word;
    end
  end

  always_comb begin
    msg   = x[k];
    t     = T_TABLE[step_q];
    shift = SHIFT_TABLE[{step_q[5:4], step_q[1:0]}];
    step  = step_q;
    rnd   = step_q[5:4];
    last  = out_valid && (step_q == 6'd63);
    done  = done_q;
  end

endmodule

// File: tb/tb_md5_msg_sched.sv
// Directed self-checking bench for md5_msg_sched.
module tb_md5_msg_sched;

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic [31:0] in_word;
  logic        in_ready;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] msg;
  logic [31:0] t;
  logic [4:0]  shift;
  logic [5:0]  step;
  logic [1:0]  rnd;
  logic        last;
  logic        done;

  int comps;
  int errs;

  md5_msg_sched dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_word   (in_word),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .msg       (msg),
    .t         (t),
    .shift     (shift),
    .step      (step),
    .rnd       (rnd),
    .last      (last),
    .done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int unsigned stp;
    logic [31:0] msg;
    logic [31:0] t;
    logic [4:0]  shift;
    logic        last;
  } vec_t;

  vec_t vecs [10];

  logic [31:0] cap_msg   [64];
  logic [31:0] cap_t     [64];
  logic [4:0]  cap_shift [64];
  logic        cap_last  [64];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    comps++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_block(input logic [31:0] base);
    for (int j = 0; j < 16; j++) begin
      in_valid = 1'b1;
      in_word  = base + 32'(j);
      tick();
    end
    in_valid = 1'b0;
    in_word  = '0;
  endtask

  task automatic wait_step(input logic [5:0] target);
    for (int n = 0; n < 200; n++) begin
      if (out_valid && step == target) break;
      tick();
    end
    chk("wait_step_reached", {26'd0, step}, {26'd0, target});
  endtask

  // Assumes X[j]=j was just loaded; consumes all 64 steps with out_ready high.
  task automatic run_table(input string tag);
    out_ready = 1'b1;
    for (int n = 0; n < 64; n++) begin
      chk({tag, "_seq_step"}, {26'd0, step}, 32'(n));
      cap_msg[n]   = msg;
      cap_t[n]     = t;
      cap_shift[n] = shift;
      cap_last[n]  = last;
      tick();
    end
    for (int v = 0; v < 10; v++) begin
      chk({tag, "_msg"},   cap_msg[vecs[v].stp], vecs[v].msg);
      chk({tag, "_t"},     cap_t[vecs[v].stp],   vecs[v].t);
      chk({tag, "_shift"}, {27'd0, cap_shift[vecs[v].stp]}, {27'd0, vecs[v].shift});
      chk({tag, "_last"},  {31'd0, cap_last[vecs[v].stp]},  {31'd0, vecs[v].last});
    end
    chk({tag, "_done_pulse"}, {31'd0, done}, 32'd1);
    chk({tag, "_ready_at_done"}, {31'd0, in_ready}, 32'd1);
    chk({tag, "_valid_at_done"}, {31'd0, out_valid}, 32'd0);
    out_ready = 1'b0;
    tick();
    chk({tag, "_done_one_cycle"}, {31'd0, done}, 32'd0);
  endtask

  int hs;
  int blk;
  int acc;
  int acc_since;
  logic        prev_hold;
  logic [31:0] prev_msg, prev_t;
  logic [4:0]  prev_shift;
  logic [5:0]  prev_step;

  initial begin
    comps = 0;
    errs  = 0;
    vecs[0] = '{stp: 0,  msg: 32'd0,  t: 32'hd76aa478, shift: 5'd7,  last: 1'b0};
    vecs[1] = '{stp: 16, msg: 32'd1,  t: 32'hf61e2562, shift: 5'd5,  last: 1'b0};
    vecs[2] = '{stp: 32, msg: 32'd5,  t: 32'hfffa3942, shift: 5'd4,  last: 1'b0};
    vecs[3] = '{stp: 48, msg: 32'd0,  t: 32'hf4292244, shift: 5'd6,  last: 1'b0};
    vecs[4] = '{stp: 63, msg: 32'd9,  t: 32'heb86d391, shift: 5'd21, last: 1'b1};
    vecs[5] = '{stp: 1,  msg: 32'd1,  t: 32'he8c7b756, shift: 5'd12, last: 1'b0};
    vecs[6] = '{stp: 15, msg: 32'd15, t: 32'h49b40821, shift: 5'd22, last: 1'b0};
    vecs[7] = '{stp: 17, msg: 32'd6,  t: 32'hc040b340, shift: 5'd9,  last: 1'b0};
    vecs[8] = '{stp: 33, msg: 32'd8,  t: 32'h8771f681, shift: 5'd11, last: 1'b0};
    vecs[9] = '{stp: 49, msg: 32'd7,  t: 32'h432aff97, shift: 5'd10, last: 1'b0};

    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_word = '0; out_ready = 1'b0;
    #12;
    chk("rst_in_ready",  {31'd0, in_ready},  32'd1);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_step",      {26'd0, step},      32'd0);
    chk("rst_done",      {31'd0, done},      32'd0);
    chk("rst_msg",       msg,                32'd0);
    #10 rst_n = 1'b1;
    tick();

    // Basic block: X[j]=j, streaming with out_ready high
    load_block(32'd0);
    chk("first_step_valid", {31'd0, out_valid}, 32'd1);
    chk("first_step_ready", {31'd0, in_ready},  32'd0);
    run_table("basic");

    // out_ready toggling
    load_block(32'd0);
    hs = 0;
    prev_hold = 1'b0;
    for (int cyc = 0; cyc < 300; cyc++) begin
      if (prev_hold && out_valid) begin
        chk("hold_msg",   msg, prev_msg);
        chk("hold_t",     t,   prev_t);
        chk("hold_shift", {27'd0, shift}, {27'd0, prev_shift});
        chk("hold_step",  {26'd0, step},  {26'd0, prev_step});
      end
      if (done) break;
      out_ready = cyc[0];
      if (out_valid && out_ready) begin
        chk("toggle_seq_step", {26'd0, step}, 32'(hs));
        hs++;
      end
      prev_hold  = out_valid && !out_ready;
      prev_msg   = msg;
      prev_t     = t;
      prev_shift = shift;
      prev_step  = step;
      tick();
    end
    chk("toggle_done_seen", {31'd0, done}, 32'd1);
    chk("toggle_handshakes", 32'(hs), 32'd64);
    out_ready = 1'b0;
    tick();

    // flush at step 30
    load_block(32'd0);
    out_ready = 1'b1;
    wait_step(6'd30);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("flush_out_valid", {31'd0, out_valid}, 32'd0);
    chk("flush_in_ready",  {31'd0, in_ready},  32'd1);
    chk("flush_no_done",   {31'd0, done},      32'd0);
    chk("flush_step",      {26'd0, step},      32'd0);
    out_ready = 1'b0;
    tick();
    chk("flush_no_done_later", {31'd0, done}, 32'd0);
    load_block(32'h100);
    chk("flush_reload_step", {26'd0, step}, 32'd0);
    chk("flush_reload_msg0", msg, 32'h100);
    out_ready = 1'b1;
    tick();
    chk("flush_reload_msg1", msg, 32'h101);
    for (int n = 0; n < 100; n++) begin
      if (done) break;
      tick();
    end
    chk("flush_reload_done", {31'd0, done}, 32'd1);
    out_ready = 1'b0;
    tick();

    // async reset at step 40
    load_block(32'd0);
    out_ready = 1'b1;
    wait_step(6'd40);
    #2 rst_n = 1'b0;
    #1;
    chk("areset_out_valid", {31'd0, out_valid}, 32'd0);
    chk("areset_in_ready",  {31'd0, in_ready},  32'd1);
    chk("areset_step",      {26'd0, step},      32'd0);
    out_ready = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    load_block(32'd0);
    run_table("after_reset");

    // back-to-back blocks with in_valid held high
    blk = 0; acc = 0; acc_since = 0;
    in_valid  = 1'b1;
    in_word   = 32'h1000;
    out_ready = 1'b1;
    for (int cyc = 0; cyc < 400; cyc++) begin
      if (out_valid) begin
        if (step == 6'd0) begin
          chk("b2b_words_per_block", 32'(acc_since), 32'd16);
          chk("b2b_x0", msg, 32'h1000 + 32'(16 * blk));
          acc_since = 0;
        end
        if (step == 6'd15) chk("b2b_x15", msg, 32'h100f + 32'(16 * blk));
        if (step == 6'd48) chk("b2b_x0_late", msg, 32'h1000 + 32'(16 * blk));
      end
      if (done) blk++;
      if (blk == 2) break;
      if (in_valid && in_ready) begin
        acc++;
        acc_since++;
      end
      tick();
      in_word = 32'h1000 + 32'(acc);
    end
    chk("b2b_blocks", 32'(blk), 32'd2);
    chk("b2b_total_words", 32'(acc), 32'd32);
    in_valid  = 1'b0;
    out_ready = 1'b0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", comps, errs);
    $finish;
  end

endmodule

// File: doc/md5_msg_sched.md
MD5_MSG_SCHED -- requirements
Module: md5_msg_sched

Interface
REQ-001 SHALL have one clock; reset is asynchronous and active-low.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 flush  input  1  synchronous abort; discards the block in progress.
REQ-005 in_valid  input  1  message word valid.
REQ-006 in_word  input  32  message word; the first accepted word is X[0], the sixteenth is X[15].
REQ-007 in_ready  output  1  scheduler accepts in_word this cycle.
REQ-008 out_valid  output  1  step outputs valid.
REQ-009 out_ready  input  1  round datapath consumes the step this cycle.
REQ-010 msg  output  32  X[k] for the current step.
REQ-011 t  output  32  T[i] constant for the current step.
REQ-012 shift  output  5  rotate amount s for the current step.
REQ-013 step  output  6  step index i, 0..63.
REQ-014 rnd  output  2  round number, step[5:4].
REQ-015 last  output  1  high when step==63 and out_valid.
REQ-016 done  output  1  one-cycle pulse after step 63 is consumed.

Function
REQ-017 SHALL use two states: LOAD and RUN.
REQ-018 LOAD behaviour: in_ready=1, out_valid=0; on in_valid&&in_ready, store in_word at X[wcnt] and increment the 4-bit wcnt.
REQ-019 LOAD exit: accepting the word with wcnt==15 SHALL move to RUN with step=0 on the next cycle; the word counter wraps to 0.
REQ-020 RUN behaviour: in_ready=0, out_valid=1; msg/t/shift/step/rnd SHALL be combinationally derived from the step register and X storage.
REQ-021 Word index k: round 0 k=i; round 1 k=(5i+1) mod 16; round 2 k=(3i+5) mod 16; round 3 k=(7i) mod 16. All use 4-bit wrap arithmetic.
REQ-022 Shift by round, cycling on i[1:0]: round 0 {7,12,17,22}; round 1 {5,9,14,20}; round 2 {4,11,16,23}; round 3 {6,10,15,21}.
REQ-023 t SHALL be T[i] per RFC 1321, i.e. floor(2^32*|sin(i+1)|).
REQ-024 Step advance: on out_valid&&out_ready, step increments; while out_ready=0, all outputs SHALL hold stable.
REQ-025 Block end: when step==63 is consumed, return to LOAD, clear step to 0, and pulse done for exactly one cycle (the cycle after the handshake).
REQ-026 Throughput: with out_ready held high, 64 consecutive cycles SHALL produce one step each, with no bubbles.
REQ-027 Next-block timing: a new block's words MAY be accepted starting the cycle done is asserted.
REQ-028 flush SHALL force LOAD with wcnt=0 and step=0 and no done pulse; flush has priority over any simultaneous handshake, and X contents are don't-care afterwards.
REQ-029 X storage SHALL be written only in LOAD; in_valid during RUN is ignored.

Reset
REQ-030 On rst_n=0: state=LOAD, wcnt=0, step=0, done=0, X cleared to 0.
REQ-031 Outputs under reset: in_ready=1 and out_valid=0 immediately (asynchronous); reset mid-RUN abandons the block.
REQ-032 Reset release SHALL be synchronised externally; the block adds no release logic.

Structure
REQ-033 Shared package md5_pkg SHALL hold: the 64-entry T constant table, the 16-entry shift table, the state enum, and the step/word width constants.
REQ-034 One sub-module, md5_k_index (step -> 4-bit k, combinational), is natural; the T lookup stays inline from md5_pkg.

Verification
REQ-035 Load X[j]=j for j=0..15, out_ready=1 -> steps 0,16,32,48 give msg=0/1/5/0, t=0xd76aa478/0xf61e2562/0xfffa3942/0xf4292244, shift=7/5/4/6.
REQ-036 Same load -> step 63: msg=9, t=0xeb86d391, shift=21, last=1; done pulses one cycle later; in_ready=1 in that cycle.
REQ-037 Toggle out_ready 0/1 each cycle during RUN -> exactly 64 handshakes, outputs stable while out_ready=0, step sequence 0..63 with no gaps.
REQ-038 Drive flush at step 30 -> next cycle LOAD, out_valid=0, no done; a fresh 16-word load then restarts at step 0.
REQ-039 Drop rst_n at step 40 -> out_valid=0 and in_ready=1 without waiting for a clock edge; a subsequent load behaves as in REQ-035.
REQ-040 Hold in_valid=1 with alternating in_ready gaps across two back-to-back blocks -> exactly 16 words per block, with the second block's X[0] equal to the 17th word sent.
